// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared types and helpers for the multi-read-port register file.
//   rf_state_t : sequencer state (RF_CLEAR while zeroing storage, RF_RUN after)
//   rf_aw(n)   : address width needed to index n registers
package regfile_pkg;

  typedef enum logic {RF_CLEAR = 1'b0, RF_RUN = 1'b1} rf_state_t;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Per-register busy vector for a pipelined datapath. A register is marked
//   busy when an instruction writing it is issued and freed on writeback.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     clear     : zero all bits (register file is in its clearing phase)
//     set_en    : mark set_reg busy
//     set_reg   : register being issued
//     clr_en    : mark clr_reg free
//     clr_reg   : register being written back
//     busy      : registered busy vector, one bit per register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             set_en,
  input  logic [AW-1:0]    set_reg,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_reg,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_next;

  // Clear is applied before set so an issue and a writeback of the same
  // register in one cycle leave it busy (the new producer is still pending).
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_reg] = 1'b0;
    if (set_en) busy_next[set_reg] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) busy <= '0;
    else              busy <= busy_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised multi-read-port integer register file for the RV32I core.
//   After reset a sequencer zeroes every register one per cycle; ready rises
//   once the last one is cleared. Reads are combinational with optional
//   same-cycle write bypass.
//   Optional feature macro: REGFILE_SCOREBOARD_EN adds a per-register busy
//   scoreboard (alloc_en, alloc_reg, read_busy ports).
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     ready       : 1 once the clearing sequence has finished
//     read_reg    : NRD read addresses
//     read_data   : NRD read results (0 while not ready)
//     write_reg   : write address
//     write_data  : write data
//     write_en    : write strobe
//     alloc_en    : (scoreboard) mark alloc_reg busy
//     alloc_reg   : (scoreboard) destination being issued
//     read_busy   : (scoreboard) busy bit of each read_reg
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = rf_aw(NREGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             ready,
  input  logic        [NRD-1:0][AW-1:0]    read_reg,
  output logic signed [NRD-1:0][XLEN-1:0]  read_data,
  input  logic        [AW-1:0]             write_reg,
  input  logic signed [XLEN-1:0]           write_data,
  input  logic                             write_en
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                             alloc_en,
  input  logic        [AW-1:0]             alloc_reg,
  output logic        [NRD-1:0]            read_busy
`endif
);

  rf_state_t        state;
  logic [AW-1:0]    cnt;
  logic [XLEN-1:0]  regs [NREGS];
  logic             write_ok;

  // A write takes effect only in RUN and never lands in a hardwired x0.
  assign write_ok = write_en && ready &&
                    !((ZERO_REG != 0) && (write_reg == '0));

  // Clearing sequencer: reset restarts it from register 0 whatever the
  // current state, and ready rises on the edge that clears the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(NREGS - 1)) begin
            state <= RF_RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= RF_RUN;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the sequencer zeroes it instead so it
  // can map onto plain flops or distributed RAM without a reset network.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_CLEAR) regs[cnt]       <= '0;
      else if (write_ok)     regs[write_reg] <= write_data;
    end
  end

  // Read ports: bypass has priority over storage so decode sees a value
  // being written back in the same cycle.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!ready) begin
        read_data[i] = '0;
      end else if ((BYPASS != 0) && write_ok && (write_reg == read_reg[i])) begin
        read_data[i] = write_data;
      end else if ((ZERO_REG != 0) && (read_reg[i] == '0)) begin
        read_data[i] = '0;
      end else begin
        read_data[i] = regs[read_reg[i]];
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == RF_CLEAR),
    .set_en  (alloc_en && ready),
    .set_reg (alloc_reg),
    .clr_en  (write_en && ready),
    .clr_reg (write_reg),
    .busy    (busy)
  );

  always_comb begin
    read_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      read_busy[i] = busy[read_reg[i]];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Drives two register files from the same stimulus: dut_a with the default
//   configuration (x0 hardwired, bypass on) and dut_b with x0 ordinary and
//   bypass off. A bench-side model predicts every output when stimulus is
//   driven; the predictions are queued and compared once outputs settle.
module tb_regfile_mp;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0][4:0]    read_reg = '0;
  logic [4:0]         write_reg = '0;
  logic signed [31:0] write_data = '0;
  logic               write_en = 1'b0;
  logic               alloc_en = 1'b0;
  logic [4:0]         alloc_reg = '0;

  logic               ready_a, ready_b;
  logic signed [1:0][31:0] rd_a, rd_b;
  logic [1:0]         busy_a, busy_b;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [31:0] ba, bb;
  logic        m_ready;
  int          m_cnt;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready_a),
    .read_reg   (read_reg),
    .read_data  (rd_a),
    .write_reg  (write_reg),
    .write_data (write_data),
    .write_en   (write_en)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .alloc_en   (alloc_en),
    .alloc_reg  (alloc_reg),
    .read_busy  (busy_a)
`endif
  );

  regfile_mp #(
    .ZERO_REG (0),
    .BYPASS   (0)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready_b),
    .read_reg   (read_reg),
    .read_data  (rd_b),
    .write_reg  (write_reg),
    .write_data (write_data),
    .write_en   (write_en)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .alloc_en   (alloc_en),
    .alloc_reg  (alloc_reg),
    .read_busy  (busy_b)
`endif
  );

`ifndef REGFILE_SCOREBOARD_EN
  assign busy_a = '0;
  assign busy_b = '0;
`endif

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_a(input logic [4:0] r);
    if (!m_ready) return 32'd0;
    if (write_en && write_reg != 5'd0 && write_reg == r) return write_data;
    if (r == 5'd0) return 32'd0;
    return ma[r];
  endfunction

  function automatic logic [31:0] exp_b(input logic [4:0] r);
    if (!m_ready) return 32'd0;
    return mb[r];
  endfunction

  // One clock of stimulus: drive, queue predictions, compare settled
  // outputs, then advance the model across the clock edge.
  task automatic apply_stimulus(input string tag, input logic r,
                                input logic we, input logic [4:0] wr,
                                input logic [31:0] wd,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic al, input logic [4:0] ar);
    logic [31:0] obs [10];
    int          n;
    rst         = r;
    write_en    = we;
    write_reg   = wr;
    write_data  = wd;
    read_reg[0] = r0;
    read_reg[1] = r1;
    alloc_en    = al;
    alloc_reg   = ar;

    exp_q.push_back('{{tag, ".rdyA"}, {31'd0, m_ready}});
    exp_q.push_back('{{tag, ".rdyB"}, {31'd0, m_ready}});
    exp_q.push_back('{{tag, ".a0"}, exp_a(r0)});
    exp_q.push_back('{{tag, ".a1"}, exp_a(r1)});
    exp_q.push_back('{{tag, ".b0"}, exp_b(r0)});
    exp_q.push_back('{{tag, ".b1"}, exp_b(r1)});
`ifdef REGFILE_SCOREBOARD_EN
    exp_q.push_back('{{tag, ".busyA0"}, {31'd0, ba[r0]}});
    exp_q.push_back('{{tag, ".busyA1"}, {31'd0, ba[r1]}});
    exp_q.push_back('{{tag, ".busyB0"}, {31'd0, bb[r0]}});
    exp_q.push_back('{{tag, ".busyB1"}, {31'd0, bb[r1]}});
    n = 10;
`else
    n = 6;
`endif

    #3;
    obs[0] = {31'd0, ready_a};
    obs[1] = {31'd0, ready_b};
    obs[2] = rd_a[0];
    obs[3] = rd_a[1];
    obs[4] = rd_b[0];
    obs[5] = rd_b[1];
    obs[6] = {31'd0, busy_a[0]};
    obs[7] = {31'd0, busy_a[1]};
    obs[8] = {31'd0, busy_b[0]};
    obs[9] = {31'd0, busy_b[1]};
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output(e.tag, obs[k], e.val);
    end

    @(posedge clk);
    if (r) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      ba      = '0;
      bb      = '0;
      for (int k = 0; k < 32; k++) begin
        ma[k] = '0;
        mb[k] = '0;
      end
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) m_ready = 1'b1;
    end else begin
      if (we) begin
        if (wr != 5'd0) ma[wr] = wd;
        mb[wr] = wd;
        ba[wr] = 1'b0;
        bb[wr] = 1'b0;
      end
      if (al) begin
        ba[ar] = 1'b1;
        bb[ar] = 1'b1;
      end
      ba[0] = 1'b0;
    end
    #1;
  endtask

  initial begin
    m_ready = 1'b0;
    m_cnt   = 0;
    ba      = '0;
    bb      = '0;
    for (int k = 0; k < 32; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end

    // Initial one-cycle reset; outputs are unknown before this edge.
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: ready stays low for exactly 32 cycles, then every register reads 0.
    for (int k = 0; k < 33; k++)
      apply_stimulus($sformatf("t1_wait%0d", k), 1'b0, 1'b0, 5'd0, 32'd0,
                     5'(k % 32), 5'(31 - (k % 32)), 1'b0, 5'd0);
    for (int k = 0; k < 32; k++)
      apply_stimulus($sformatf("t1_rd%0d", k), 1'b0, 1'b0, 5'd0, 32'd0,
                     5'(k), 5'(31 - k), 1'b0, 5'd0);

    // T2: two writes in separate cycles, then read both back.
    apply_stimulus("t2_w10", 1'b0, 1'b1, 5'd10, 32'd12983, 5'd10, 5'd30, 1'b0, 5'd0);
    apply_stimulus("t2_w30", 1'b0, 1'b1, 5'd30, 32'd324,   5'd10, 5'd30, 1'b0, 5'd0);
    apply_stimulus("t2_rd",  1'b0, 1'b0, 5'd0,  32'd0,     5'd10, 5'd30, 1'b0, 5'd0);

    // T3: write to x0 is dropped only where x0 is hardwired.
    apply_stimulus("t3_w0", 1'b0, 1'b1, 5'd0, 32'd500, 5'd0, 5'd0, 1'b0, 5'd0);
    apply_stimulus("t3_rd", 1'b0, 1'b0, 5'd0, 32'd0,   5'd0, 5'd0, 1'b0, 5'd0);

    // T4: same-cycle bypass of a negative value, then visible in storage.
    apply_stimulus("t4_byp", 1'b0, 1'b1, 5'd5, -32'sd7, 5'd5, 5'd10, 1'b0, 5'd0);
    apply_stimulus("t4_rd",  1'b0, 1'b0, 5'd0, 32'd0,   5'd5, 5'd5,  1'b0, 5'd0);

    // T6: busy set, set-wins over clear, then cleared by writeback.
    apply_stimulus("t6_alloc", 1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 5'd7);
    apply_stimulus("t6_both",  1'b0, 1'b1, 5'd7, 32'd1, 5'd7, 5'd7, 1'b1, 5'd7);
    apply_stimulus("t6_wr",    1'b0, 1'b1, 5'd7, 32'd2, 5'd7, 5'd0, 1'b0, 5'd0);
    apply_stimulus("t6_chk",   1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b1, 5'd0);

    // Random mix of writes, allocations and reads.
    for (int k = 0; k < 60; k++)
      apply_stimulus($sformatf("rnd%0d", k), 1'b0, 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)), $urandom,
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

    // T5: x3 nonzero, reset, re-reset mid-clear with writes hammering x3.
    apply_stimulus("t5_w3", 1'b0, 1'b1, 5'd3, 32'd55, 5'd3, 5'd3, 1'b0, 5'd0);
    apply_stimulus("t5_rst1", 1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0, 5'd0);
    for (int k = 0; k < 10; k++)
      apply_stimulus($sformatf("t5_c%0d", k), 1'b0, 1'b1, 5'd3, 32'd99,
                     5'd3, 5'd0, 1'b1, 5'd3);
    apply_stimulus("t5_rst2", 1'b1, 1'b1, 5'd3, 32'd99, 5'd3, 5'd0, 1'b0, 5'd0);
    for (int k = 0; k < 33; k++)
      apply_stimulus($sformatf("t5_wait%0d", k), 1'b0, 1'b1, 5'd3, 32'd99,
                     5'd3, 5'd0, 1'b1, 5'd3);
    apply_stimulus("t5_rd", 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
